// File: rtl/fp_recip_refine_if.sv
// Handshake bundle for the reciprocal stage: operand side (in_*) and
// result side (out_*). The block is the slave; the producer/consumer pair
// driving it is the master.
interface fp_recip_refine_if;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] fp_in;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] fp_out;

  modport master (
    output in_valid,
    output fp_in,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  fp_out
  );

  modport slave (
    input  in_valid,
    input  fp_in,
    input  out_ready,
    output in_ready,
    output out_valid,
    output fp_out
  );
endinterface

// File: rtl/fp_recip_refine.sv
// Binary32 reciprocal: specials decoded at accept, normal operands go
// through a linear seed plus ITER Newton-Raphson steps in Q2.30, using a
// single shared 32x32 multiplier (one product per cycle).
module fp_recip_refine #(
  parameter int ITER = 3
) (
  input logic              clk,
  input logic              rst_n,
  fp_recip_refine_if.slave io_bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SEED  = 3'd1,
    MUL_A = 3'd2,
    MUL_B = 3'd3,
    PACK  = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      r_state;
  logic        r_in_ready;
  logic        r_out_valid;
  logic [31:0] r_fp_out;
  logic [31:0] r_res;      // special-case result waiting to be published
  logic        r_s;
  logic [7:0]  r_e;
  logic [31:0] r_d;        // m/2 in Q2.30
  logic [31:0] r_x;        // current reciprocal estimate of d, Q2.30
  logic [31:0] r_t;        // d*x, Q2.30
  logic [2:0]  r_cnt;

  // operand fields straight off the bus
  logic        w_in_s;
  logic [7:0]  w_in_e;
  logic [22:0] w_in_f;
  logic        w_special;
  logic [31:0] w_spec_res;

  assign w_in_s = io_bus.fp_in[31];
  assign w_in_e = io_bus.fp_in[30:23];
  assign w_in_f = io_bus.fp_in[22:0];
  assign w_special = (w_in_e == 8'hFF) || (w_in_e == 8'h00) || (w_in_f == 23'd0);

  // Decode NaN / inf / zero / exact power-of-two results at accept time
  always_comb begin
    w_spec_res = 32'd0;
    if (w_in_e == 8'hFF) begin
      if (w_in_f != 23'd0) begin
        w_spec_res = 32'h7FC0_0000;
      end else begin
        w_spec_res = {w_in_s, 31'd0};
      end
    end else if (w_in_e == 8'h00) begin
      w_spec_res = {w_in_s, 8'hFF, 23'd0};
    end else if (w_in_f == 23'd0) begin
      if (w_in_e == 8'd254) begin
        w_spec_res = {w_in_s, 31'd0};
      end else begin
        w_spec_res = {w_in_s, 8'd254 - w_in_e, 23'd0};
      end
    end else begin
      w_spec_res = 32'd0;
    end
  end

  // shared multiplier, operands steered by the current step
  logic [31:0] w_mul_a;
  logic [31:0] w_mul_b;
  logic [63:0] w_prod;
  logic [31:0] w_prod_sh;

  // Select multiplier operands: seed slope, d*x, or x*(2-t)
  always_comb begin
    w_mul_a = 32'd0;
    w_mul_b = 32'd0;
    case (r_state)
      SEED: begin
        w_mul_a = 32'h7878_7878;
        w_mul_b = r_d;
      end
      MUL_A: begin
        w_mul_a = r_d;
        w_mul_b = r_x;
      end
      MUL_B: begin
        w_mul_a = r_x;
        w_mul_b = 32'h8000_0000 - r_t;
      end
      default: begin
        w_mul_a = 32'd0;
        w_mul_b = 32'd0;
      end
    endcase
  end

  assign w_prod    = {32'd0, w_mul_a} * {32'd0, w_mul_b};
  assign w_prod_sh = 32'(w_prod >> 6'd30);

  // packing of the refined estimate x in (1,2): result = x * 2^(126-e)
  logic [23:0] w_mant_sum;
  logic        w_carry;
  logic        w_flush;
  logic [7:0]  w_pack_exp;
  logic [31:0] w_pack;

  assign w_mant_sum = {1'b0, r_x[29:7]} + {23'd0, r_x[6]};
  assign w_carry    = w_mant_sum[23];
  assign w_flush    = (r_e >= 8'd253);
  assign w_pack_exp = 8'd253 - r_e + {7'd0, w_carry};

  // Assemble the normal-path result, flushing tiny results to signed zero
  always_comb begin
    w_pack = {r_s, 31'd0};
    if (w_flush) begin
      w_pack = {r_s, 31'd0};
    end else if (w_carry) begin
      w_pack = {r_s, w_pack_exp, 23'd0};
    end else begin
      w_pack = {r_s, w_pack_exp, w_mant_sum[22:0]};
    end
  end

  // Control FSM with all datapath registers and registered handshake outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_fp_out    <= 32'd0;
      r_res       <= 32'd0;
      r_s         <= 1'b0;
      r_e         <= 8'd0;
      r_d         <= 32'd0;
      r_x         <= 32'd0;
      r_t         <= 32'd0;
      r_cnt       <= 3'd0;
    end else begin
      case (r_state)
        IDLE: begin
          if (io_bus.in_valid && r_in_ready) begin
            r_in_ready <= 1'b0;
            r_s        <= w_in_s;
            r_e        <= w_in_e;
            r_d        <= {2'b00, 1'b1, w_in_f, 6'd0};
            r_cnt      <= 3'd0;
            r_res      <= w_spec_res;
            if (w_special) begin
              r_state <= DONE;
            end else begin
              r_state <= SEED;
            end
          end
        end
        SEED: begin
          // x0 = 48/17 - (32/17)*d
          r_x     <= 32'hB4B4_B4B5 - w_prod_sh;
          r_state <= MUL_A;
        end
        MUL_A: begin
          r_t     <= w_prod_sh;
          r_state <= MUL_B;
        end
        MUL_B: begin
          r_x   <= w_prod_sh;
          r_cnt <= r_cnt + 3'd1;
          if (r_cnt + 3'd1 == 3'(ITER)) begin
            r_state <= PACK;
          end else begin
            r_state <= MUL_A;
          end
        end
        PACK: begin
          r_out_valid <= 1'b1;
          r_fp_out    <= w_pack;
          r_state     <= DONE;
        end
        DONE: begin
          // specials arrive here without out_valid; publish one cycle later
          if (!r_out_valid) begin
            r_out_valid <= 1'b1;
            r_fp_out    <= r_res;
          end else if (io_bus.out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.fp_out    = r_fp_out;

endmodule

// File: tb/tb_fp_recip_refine.sv
// Directed bench for fp_recip_refine (ITER=3): specials, normal operands
// with a 1-ulp window, latency, backpressure and mid-operation reset.
module tb_fp_recip_refine;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  fp_recip_refine_if bus ();

  fp_recip_refine #(.ITER(3)) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .io_bus (bus)
  );

  int n_cmp = 0;
  int n_err = 0;

  // Compare observed against expected with a tolerance in ulps (same sign required)
  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp, input int unsigned tol);
    logic [31:0] dd;
    n_cmp++;
    dd = (obs > exp) ? (obs - exp) : (exp - obs);
    if ($isunknown(obs) || (obs[31] != exp[31]) || (dd > 32'(tol))) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  // Wait for out_valid after an accept edge; returns edges elapsed (bounded)
  task automatic wait_result(output int cyc);
    cyc = 0;
    while (!bus.out_valid && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  // One full transaction with out_ready held high
  task automatic do_op(input string tag, input logic [31:0] a,
                       input logic [31:0] exp, input int unsigned tol, input int lat);
    int cyc;
    check_val({tag, "_rdy"}, {31'd0, bus.in_ready}, 32'd1, 0);
    bus.fp_in    = a;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.fp_in    = ~a;
    check_val({tag, "_busy"}, {31'd0, bus.in_ready}, 32'd0, 0);
    wait_result(cyc);
    check_val({tag, "_lat"}, 32'(cyc), 32'(lat), 0);
    check_val(tag, bus.fp_out, exp, tol);
    @(posedge clk); #1;
    check_val({tag, "_ov0"}, {31'd0, bus.out_valid}, 32'd0, 0);
    check_val({tag, "_ir1"}, {31'd0, bus.in_ready}, 32'd1, 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc;
    logic [31:0] hold;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.fp_in     = 32'd0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", {31'd0, bus.in_ready}, 32'd1, 0);
    check_val("rst_out_valid", {31'd0, bus.out_valid}, 32'd0, 0);
    check_val("rst_fp_out", bus.fp_out, 32'd0, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // normal path and powers of two
    do_op("three",   32'h4040_0000, 32'h3EAA_AAAB, 1, 8);
    do_op("two",     32'h4000_0000, 32'h3F00_0000, 0, 1);
    do_op("neg_one", 32'hBF80_0000, 32'hBF80_0000, 0, 1);
    do_op("neg_three", 32'hC040_0000, 32'hBEAA_AAAB, 1, 8);
    do_op("one_half", 32'h3FC0_0000, 32'h3F2A_AAAB, 1, 8);
    do_op("seven",   32'h40E0_0000, 32'h3E12_4925, 1, 8);
    do_op("near_one", 32'h3F80_0001, 32'h3F7F_FFFE, 1, 8);
    do_op("e252",    32'h7E40_0000, 32'h00AA_AAAB, 1, 8);
    do_op("pow_e253", 32'h7E80_0000, 32'h0080_0000, 0, 1);
    do_op("pow_e254", 32'h7F00_0000, 32'h0000_0000, 0, 1);

    // specials
    do_op("zero",    32'h0000_0000, 32'h7F80_0000, 0, 1);
    do_op("denorm",  32'h8000_0001, 32'hFF80_0000, 0, 1);
    do_op("neg_inf", 32'hFF80_0000, 32'h8000_0000, 0, 1);
    do_op("pos_inf", 32'h7F80_0000, 32'h0000_0000, 0, 1);
    do_op("nan",     32'h7FC0_0001, 32'h7FC0_0000, 0, 1);
    do_op("e253_flush", 32'h7EC0_0000, 32'h0000_0000, 0, 8);

    // backpressure: result held, inputs ignored while busy
    bus.out_ready = 1'b0;
    check_val("bp_rdy", {31'd0, bus.in_ready}, 32'd1, 0);
    bus.fp_in    = 32'h4040_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    wait_result(cyc);
    check_val("bp_lat", 32'(cyc), 32'd8, 0);
    hold = bus.fp_out;
    check_val("bp_val", hold, 32'h3EAA_AAAB, 1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = i[0];
      bus.fp_in    = 32'h3F80_0000 + 32'(i);
      @(posedge clk); #1;
      check_val("bp_stable", bus.fp_out, hold, 0);
      check_val("bp_ov", {31'd0, bus.out_valid}, 32'd1, 0);
      check_val("bp_ir", {31'd0, bus.in_ready}, 32'd0, 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    check_val("bp_ov0", {31'd0, bus.out_valid}, 32'd0, 0);
    check_val("bp_ir1", {31'd0, bus.in_ready}, 32'd1, 0);
    repeat (3) @(posedge clk);
    #1;
    check_val("bp_no_accept", {31'd0, bus.out_valid}, 32'd0, 0);

    // reset during MUL_B of the second iteration
    bus.fp_in    = 32'h40E0_0000;
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check_val("mid_rst_ov", {31'd0, bus.out_valid}, 32'd0, 0);
    check_val("mid_rst_ir", {31'd0, bus.in_ready}, 32'd1, 0);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    check_val("mid_rst_no_emit", {31'd0, bus.out_valid}, 32'd0, 0);
    do_op("ten", 32'h4120_0000, 32'h3DCC_CCCD, 1, 8);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
